// File: rtl/gol_step_engine_if.sv
// Board interface between the Game of Life step engine (master, board writer)
// and its consumers such as the VGA renderer and the seeding/control logic (slave).
interface gol_step_engine_if #(
  parameter int HEIGHT = 20,
  parameter int WIDTH  = 20
);
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                          step;
  logic                          clear;
  logic                          load_valid;
  logic [ROW_W-1:0]              load_row;
  logic [COL_W-1:0]              load_col;
  logic                          load_alive;
  logic [0:HEIGHT-1][0:WIDTH-1]  board;
  logic                          busy;
  logic                          done;
  logic [15:0]                   generation;

  modport master (
    input  step, clear, load_valid, load_row, load_col, load_alive,
    output board, busy, done, generation
  );

  modport slave (
    output step, clear, load_valid, load_row, load_col, load_alive,
    input  board, busy, done, generation
  );
endinterface

// File: rtl/gol_step_engine.sv
// Game of Life generation engine: evaluates one cell per clock into a shadow
// buffer and commits the whole generation to the displayed board in one cycle.
//
// state   | meaning
// IDLE    | accepts clear / single-cell load / step requests
// COMPUTE | walks cells row-major, writing next-state values into shadow
// COMMIT  | copies shadow to board, bumps generation, raises done next cycle
module gol_step_engine #(
  parameter int HEIGHT = 20,
  parameter int WIDTH  = 20,
  parameter int WRAP   = 1
) (
  input logic               clk_25,
  input logic               reset,
  gol_step_engine_if.master bus
);
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  logic [1:0]                   state;
  logic [ROW_W-1:0]             row;
  logic [COL_W-1:0]             col;
  logic [0:HEIGHT-1][0:WIDTH-1] board_q;
  logic [0:HEIGHT-1][0:WIDTH-1] shadow;
  logic                         done_q;
  logic [15:0]                  gen_q;

  logic [ROW_W-1:0] row_m, row_p;
  logic [COL_W-1:0] col_m, col_p;
  logic             row_m_ok, row_p_ok, col_m_ok, col_p_ok;
  logic [3:0]       count;
  logic             next_cell;
  logic             last_cell;
  logic             load_ok;

  // Neighbour coordinates; the *_ok flags mask off-board cells when not wrapping.
  always_comb begin
    row_m    = (row == '0) ? ROW_W'(HEIGHT - 1) : row - ROW_W'(1);
    row_p    = (row == ROW_W'(HEIGHT - 1)) ? '0 : row + ROW_W'(1);
    col_m    = (col == '0) ? COL_W'(WIDTH - 1) : col - COL_W'(1);
    col_p    = (col == COL_W'(WIDTH - 1)) ? '0 : col + COL_W'(1);
    row_m_ok = (WRAP != 0) || (row != '0);
    row_p_ok = (WRAP != 0) || (row != ROW_W'(HEIGHT - 1));
    col_m_ok = (WRAP != 0) || (col != '0);
    col_p_ok = (WRAP != 0) || (col != COL_W'(WIDTH - 1));
  end

  always_comb begin
    count = {3'b000, row_m_ok & col_m_ok & board_q[row_m][col_m]}
          + {3'b000, row_m_ok            & board_q[row_m][col]}
          + {3'b000, row_m_ok & col_p_ok & board_q[row_m][col_p]}
          + {3'b000,            col_m_ok & board_q[row][col_m]}
          + {3'b000,            col_p_ok & board_q[row][col_p]}
          + {3'b000, row_p_ok & col_m_ok & board_q[row_p][col_m]}
          + {3'b000, row_p_ok            & board_q[row_p][col]}
          + {3'b000, row_p_ok & col_p_ok & board_q[row_p][col_p]};
    next_cell = (count == 4'd3) | (board_q[row][col] & (count == 4'd2));
  end

  assign last_cell = (row == ROW_W'(HEIGHT - 1)) && (col == COL_W'(WIDTH - 1));
  assign load_ok   = bus.load_valid
                   && (int'(bus.load_row) < HEIGHT)
                   && (int'(bus.load_col) < WIDTH);

  always_ff @(posedge clk_25) begin
    if (reset) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      board_q <= '0;
      shadow  <= '0;
      done_q  <= 1'b0;
      gen_q   <= 16'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear) begin
            board_q <= '0;
          end else if (load_ok) begin
            board_q[bus.load_row][bus.load_col] <= bus.load_alive;
          end
          if (bus.step) begin
            state <= COMPUTE;
            row   <= '0;
            col   <= '0;
          end
        end
        COMPUTE: begin
          shadow[row][col] <= next_cell;
          if (last_cell) begin
            state <= COMMIT;
            row   <= '0;
            col   <= '0;
          end else if (col == COL_W'(WIDTH - 1)) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
        COMMIT: begin
          board_q <= shadow;
          gen_q   <= gen_q + 16'd1;
          done_q  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // busy spans COMPUTE and the commit cycle so it drops exactly when done rises.
  assign bus.busy       = (state != IDLE);
  assign bus.board      = board_q;
  assign bus.done       = done_q;
  assign bus.generation = gen_q;
endmodule
